jtgng_linebuf_ctrl: RTL

//  Ping-pong scan-line buffer controller, upstream of a 1R/1W dual-port RAM (registered read, 1-clk latency).

---
 rtl/jtgng_linebuf_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/jtgng_linebuf_ctrl.sv
// jtgng_linebuf_ctrl
// Ping-pong scan-line buffer controller placed in front of a 1R/1W dual-port RAM
// with a registered read (1 clk latency). The object drawer fills line N+1 in one
// bank while the video side reads line N from the other bank. The banks swap on
// every falling edge of LHBL.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cen               pixel clock enable for the read side
//   LHBL              line blank, low while blanking
//   draw_x/pxl/we     drawer write request (column, pixel value, request)
//   draw_ready        a request is accepted on this clk when high
//   ram_wr_addr/data  RAM write port; ram_we pulses for one clk per write
//   ram_rd_addr       RAM read address {~bank, rd_cnt}
//   ram_q             RAM read data, valid one clk after ram_rd_addr
//   pxl_out           pixel to the video mixer; BLANK during blanking and reset
//
// Configuration
//   JTGNG_LINEBUF_ERASE_EN  when defined, the clk after every read issue is an erase
//                           slot that writes BLANK back to the address just read.
//                           Pending pixels equal to BLANK are then not written.
//                           When undefined, the drawer owns the write port every clk.

`timescale 1ns/1ps

module jtgng_linebuf_ctrl #(
  parameter int unsigned    DW    = 8,
  parameter int unsigned    LW    = 9,
  parameter logic [DW-1:0]  BLANK = DW'('hF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          LHBL,
  input  logic [LW-1:0] draw_x,
  input  logic [DW-1:0] draw_pxl,
  input  logic          draw_we,
  output logic          draw_ready,
  output logic [LW:0]   ram_wr_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  output logic [LW:0]   ram_rd_addr,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] pxl_out
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          bank_q,     bank_d;      // bank currently being drawn
  logic          lhbl_q;                  // LHBL from the previous clk, for edge detect
  logic [LW-1:0] rd_cnt_q,   rd_cnt_d;
  logic          rd_issue_q;              // a read was issued on the previous clk
  logic [DW-1:0] pxl_q,      pxl_d;

  // One-entry pending draw register
  logic          pend_q,     pend_d;
  logic          pbank_q,    pbank_d;
  logic [LW-1:0] px_q,       px_d;
  logic [DW-1:0] ppxl_q,     ppxl_d;

  // Per-clk control
  logic          lhbl_fall;
  logic          rd_issue;
  logic          write_free;              // write port not claimed by an erase slot
  logic          drain;                   // pending entry leaves the register this clk
  logic          xfer;                    // drawer handshake completes this clk

`ifdef JTGNG_LINEBUF_ERASE_EN
  logic          erase_q;
  logic [LW:0]   erase_addr_q;
`endif

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  assign lhbl_fall   = lhbl_q & ~LHBL;
  assign rd_issue    = cen & LHBL;
  assign ram_rd_addr = {~bank_q, rd_cnt_q};
  assign pxl_out     = pxl_q;

  always_comb begin
    bank_d   = bank_q;
    rd_cnt_d = rd_cnt_q;
    if (lhbl_fall) begin
      bank_d   = ~bank_q;
      rd_cnt_d = '0;
    end else if (rd_issue) begin
      rd_cnt_d = rd_cnt_q + LW'(1);
    end
  end

  // ram_q holds the word addressed on the previous issue, so it is captured one
  // clk after that issue.
  always_comb begin
    pxl_d = pxl_q;
    if (!LHBL) begin
      pxl_d = BLANK;
    end else if (rd_issue_q) begin
      pxl_d = ram_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port arbitration and draw handshake
  // ---------------------------------------------------------------------------
`ifdef JTGNG_LINEBUF_ERASE_EN
  assign write_free = ~erase_q;
`else
  assign write_free = 1'b1;
`endif

  assign drain      = pend_q & write_free;
  assign draw_ready = ~pend_q | write_free;
  assign xfer       = draw_we & draw_ready;

  always_comb begin
    pend_d  = pend_q;
    pbank_d = pbank_q;
    px_d    = px_q;
    ppxl_d  = ppxl_q;
    if (xfer) begin
      // The bank is latched at capture, so a swap while pending cannot move it.
      pend_d  = 1'b1;
      pbank_d = bank_q;
      px_d    = draw_x;
      ppxl_d  = draw_pxl;
    end else if (drain) begin
      pend_d  = 1'b0;
    end
  end

  always_comb begin
    ram_we      = 1'b0;
    ram_wr_addr = '0;
    ram_data    = '0;
`ifdef JTGNG_LINEBUF_ERASE_EN
    if (erase_q) begin
      ram_we      = 1'b1;
      ram_wr_addr = erase_addr_q;
      ram_data    = BLANK;
    end else if (pend_q && (ppxl_q != BLANK)) begin
      // BLANK pixels complete the handshake but the erase already cleared them.
      ram_we      = 1'b1;
      ram_wr_addr = {pbank_q, px_q};
      ram_data    = ppxl_q;
    end
`else
    if (pend_q) begin
      ram_we      = 1'b1;
      ram_wr_addr = {pbank_q, px_q};
      ram_data    = ppxl_q;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= 1'b0;
      lhbl_q     <= 1'b0;
      rd_cnt_q   <= '0;
      rd_issue_q <= 1'b0;
      pxl_q      <= BLANK;
      pend_q     <= 1'b0;
      pbank_q    <= 1'b0;
      px_q       <= '0;
      ppxl_q     <= '0;
    end else begin
      bank_q     <= bank_d;
      lhbl_q     <= LHBL;
      rd_cnt_q   <= rd_cnt_d;
      rd_issue_q <= rd_issue;
      pxl_q      <= pxl_d;
      pend_q     <= pend_d;
      pbank_q    <= pbank_d;
      px_q       <= px_d;
      ppxl_q     <= ppxl_d;
    end
  end

`ifdef JTGNG_LINEBUF_ERASE_EN
  // The erase slot follows each read issue and targets the address just read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erase_q      <= 1'b0;
      erase_addr_q <= '0;
    end else begin
      erase_q      <= rd_issue;
      erase_addr_q <= ram_rd_addr;
    end
  end
`endif

endmodule
